// File: rtl/gray_chk_pkg.sv
// Shared definitions for the Gray-code step checker.
//   - default parameter values for WIDTH, ERR_CNT_W and LOCK_N
//   - lock state machine encoding
//   - step classification encoding
package gray_chk_pkg;

    localparam int unsigned DEF_WIDTH     = 4;
    localparam int unsigned DEF_ERR_CNT_W = 8;
    localparam int unsigned DEF_LOCK_N    = 2;

    // Explicit values keep the encoding stable for legacy consumers.
    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        LOCKED   = 2'd1,
        UNLOCKED = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        STEP_UP  = 2'd0,
        STEP_DN  = 2'd1,
        STEP_BAD = 2'd2
    } step_e;

endpackage

// File: rtl/gray_step_checker_gray2bin.sv
// Combinational Gray-to-binary converter.
//   gray_i : Gray-coded word
//   bin_o  : binary equivalent (MSB passes through, each lower bit is the
//            XOR of the binary bit above it and its own Gray bit)
module gray2bin #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    always_comb begin
        bin_o = '0;
        bin_o[WIDTH-1] = gray_i[WIDTH-1];
        for (int unsigned k = 1; k < WIDTH; k++) begin
            bin_o[WIDTH-1-k] = bin_o[WIDTH-k] ^ gray_i[WIDTH-1-k];
        end
    end

endmodule

// File: rtl/gray_step_checker.sv
// Gray-code stream step checker.
// Accepts Gray words over valid/ready, converts them to binary, checks each
// word is exactly +/-1 (mod 2^WIDTH) from the previous one, tracks lock and
// a saturating error count, and presents the result in a registered stage.
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : input handshake, in_gray is the Gray word
//   out_valid/out_ready : output handshake
//   out_bin           : binary value of the accepted word
//   out_dir           : 1 = up step, 0 = down step (held on bad steps)
//   out_err           : accepted word was not a +/-1 step
//   locked            : lock state machine is in LOCKED
//   err_count         : saturating count of bad beats
module gray_step_checker
    import gray_chk_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned ERR_CNT_W = DEF_ERR_CNT_W,
    parameter int unsigned LOCK_N    = DEF_LOCK_N
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_gray,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_bin,
    output logic                 out_dir,
    output logic                 out_err,
    output logic                 locked,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int unsigned RUN_W = $clog2(LOCK_N + 1);
    localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(LOCK_N);

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     ref_q, ref_d;
    logic [RUN_W-1:0]     bad_run_q, bad_run_d;
    logic [RUN_W-1:0]     good_run_q, good_run_d;
    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     out_bin_q, out_bin_d;
    logic                 out_dir_q, out_dir_d;
    logic                 out_err_q, out_err_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

    logic [WIDTH-1:0] bin;
    logic [WIDTH-1:0] ref_inc, ref_dec;
    logic [RUN_W-1:0] bad_inc, good_inc;
    logic             accept;
    step_e            step;

    gray2bin #(.WIDTH(WIDTH)) u_gray2bin (
        .gray_i (in_gray),
        .bin_o  (bin)
    );

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Wrap-around falls out of the WIDTH-bit modular arithmetic.
    assign ref_inc  = ref_q + 1'b1;
    assign ref_dec  = ref_q - 1'b1;
    assign bad_inc  = bad_run_q + 1'b1;
    assign good_inc = good_run_q + 1'b1;

    always_comb begin
        if (bin == ref_inc)      step = STEP_UP;
        else if (bin == ref_dec) step = STEP_DN;
        else                     step = STEP_BAD;
    end

    always_comb begin
        state_d     = state_q;
        ref_d       = ref_q;
        bad_run_d   = bad_run_q;
        good_run_d  = good_run_q;
        out_valid_d = out_valid_q;
        out_bin_d   = out_bin_q;
        out_dir_d   = out_dir_q;
        out_err_d   = out_err_q;
        err_count_d = err_count_q;

        if (accept) begin
            // A new accept replaces any result consumed this cycle, so
            // out_valid stays high without a bubble.
            out_valid_d = 1'b1;
            out_bin_d   = bin;
            ref_d       = bin;

            case (state_q)
                LOCKED, UNLOCKED: begin
                    out_err_d = (step == STEP_BAD);
                    if (step == STEP_UP)      out_dir_d = 1'b1;
                    else if (step == STEP_DN) out_dir_d = 1'b0;

                    if (step == STEP_BAD && err_count_q != '1) begin
                        err_count_d = err_count_q + 1'b1;
                    end

                    if (state_q == LOCKED) begin
                        if (step == STEP_BAD) begin
                            if (bad_inc == RUN_LIMIT) begin
                                state_d   = UNLOCKED;
                                bad_run_d = '0;
                            end else begin
                                bad_run_d = bad_inc;
                            end
                        end else begin
                            bad_run_d = '0;
                        end
                    end else begin
                        if (step != STEP_BAD) begin
                            if (good_inc == RUN_LIMIT) begin
                                state_d    = LOCKED;
                                good_run_d = '0;
                            end else begin
                                good_run_d = good_inc;
                            end
                        end else begin
                            good_run_d = '0;
                        end
                    end
                end
                default: begin
                    // First word after reset only establishes the reference.
                    state_d    = LOCKED;
                    out_err_d  = 1'b0;
                    out_dir_d  = 1'b0;
                    bad_run_d  = '0;
                    good_run_d = '0;
                end
            endcase
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            ref_q       <= '0;
            bad_run_q   <= '0;
            good_run_q  <= '0;
            out_valid_q <= 1'b0;
            out_bin_q   <= '0;
            out_dir_q   <= 1'b0;
            out_err_q   <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            ref_q       <= ref_d;
            bad_run_q   <= bad_run_d;
            good_run_q  <= good_run_d;
            out_valid_q <= out_valid_d;
            out_bin_q   <= out_bin_d;
            out_dir_q   <= out_dir_d;
            out_err_q   <= out_err_d;
            err_count_q <= err_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_bin   = out_bin_q;
    assign out_dir   = out_dir_q;
    assign out_err   = out_err_q;
    assign locked    = (state_q == LOCKED);
    assign err_count = err_count_q;

endmodule

// File: tb/tb_gray_step_checker.sv
module tb_gray_step_checker;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance: default parameters.
    logic       rst, in_valid, out_ready;
    logic [3:0] in_gray;
    logic       in_ready, out_valid, out_dir, out_err, locked;
    logic [3:0] out_bin;
    logic [7:0] err_count;

    // Saturation instance: 2-bit error counter.
    logic       rst2, in_valid2, out_ready2;
    logic [3:0] in_gray2;
    logic       in_ready2, out_valid2, out_dir2, out_err2, locked2;
    logic [3:0] out_bin2;
    logic [1:0] err_count2;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    gray_step_checker #(.WIDTH(4), .ERR_CNT_W(8), .LOCK_N(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_gray(in_gray), .out_valid(out_valid), .out_ready(out_ready),
        .out_bin(out_bin), .out_dir(out_dir), .out_err(out_err),
        .locked(locked), .err_count(err_count)
    );

    gray_step_checker #(.WIDTH(4), .ERR_CNT_W(2), .LOCK_N(2)) dut_sat (
        .clk(clk), .rst(rst2), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_gray(in_gray2), .out_valid(out_valid2), .out_ready(out_ready2),
        .out_bin(out_bin2), .out_dir(out_dir2), .out_err(out_err2),
        .locked(locked2), .err_count(err_count2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply inputs, advance one edge, settle.
    task automatic beat(input logic r, input logic v, input logic [3:0] g, input logic rdy);
        rst = r; in_valid = v; in_gray = g; out_ready = rdy;
        @(posedge clk); #1;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] b, input logic d,
                              input logic e, input logic lk, input logic [7:0] cnt);
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".bin"},   32'(out_bin),   32'(b));
        chk({tag, ".dir"},   32'(out_dir),   32'(d));
        chk({tag, ".err"},   32'(out_err),   32'(e));
        chk({tag, ".lock"},  32'(locked),    32'(lk));
        chk({tag, ".cnt"},   32'(err_count), 32'(cnt));
    endtask

    task automatic expect_reset(input string tag);
        chk({tag, ".valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".bin"},   32'(out_bin),   32'd0);
        chk({tag, ".dir"},   32'(out_dir),   32'd0);
        chk({tag, ".err"},   32'(out_err),   32'd0);
        chk({tag, ".lock"},  32'(locked),    32'd0);
        chk({tag, ".cnt"},   32'(err_count), 32'd0);
    endtask

    task automatic beat2(input logic r, input logic v, input logic [3:0] g);
        rst2 = r; in_valid2 = v; in_gray2 = g; out_ready2 = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        rst2 = 1'b1; in_valid2 = 1'b0; in_gray2 = 4'b0000; out_ready2 = 1'b1;

        // Reset state
        beat(1'b1, 1'b0, 4'b0000, 1'b1);
        beat(1'b1, 1'b0, 4'b0000, 1'b1);
        expect_reset("rst");
        chk("rst.in_ready", 32'(in_ready), 32'd1);

        // Count up 0..3
        beat(1'b0, 1'b1, 4'b0000, 1'b1); expect_out("up0", 4'd0, 1'b0, 1'b0, 1'b1, 8'd0);
        beat(1'b0, 1'b1, 4'b0001, 1'b1); expect_out("up1", 4'd1, 1'b1, 1'b0, 1'b1, 8'd0);
        beat(1'b0, 1'b1, 4'b0011, 1'b1); expect_out("up2", 4'd2, 1'b1, 1'b0, 1'b1, 8'd0);
        beat(1'b0, 1'b1, 4'b0010, 1'b1); expect_out("up3", 4'd3, 1'b1, 1'b0, 1'b1, 8'd0);

        // Count down to 0, then wrap both ways
        beat(1'b0, 1'b1, 4'b0011, 1'b1); expect_out("dn2",  4'd2,  1'b0, 1'b0, 1'b1, 8'd0);
        beat(1'b0, 1'b1, 4'b0001, 1'b1); expect_out("dn1",  4'd1,  1'b0, 1'b0, 1'b1, 8'd0);
        beat(1'b0, 1'b1, 4'b0000, 1'b1); expect_out("dn0",  4'd0,  1'b0, 1'b0, 1'b1, 8'd0);
        beat(1'b0, 1'b1, 4'b1000, 1'b1); expect_out("wdn15", 4'd15, 1'b0, 1'b0, 1'b1, 8'd0);
        beat(1'b0, 1'b1, 4'b0000, 1'b1); expect_out("wup0",  4'd0,  1'b1, 1'b0, 1'b1, 8'd0);
        beat(1'b0, 1'b1, 4'b1000, 1'b1); expect_out("wdn15b", 4'd15, 1'b0, 1'b0, 1'b1, 8'd0);
        beat(1'b0, 1'b1, 4'b0000, 1'b1); expect_out("wup0b", 4'd0,  1'b1, 1'b0, 1'b1, 8'd0);

        // Errors and lock loss: dir holds its last good value
        beat(1'b0, 1'b1, 4'b0011, 1'b1); expect_out("bad2", 4'd2, 1'b1, 1'b1, 1'b1, 8'd1);
        beat(1'b0, 1'b1, 4'b0111, 1'b1); expect_out("bad5", 4'd5, 1'b1, 1'b1, 1'b0, 8'd2);
        // Regain lock
        beat(1'b0, 1'b1, 4'b0101, 1'b1); expect_out("good6", 4'd6, 1'b1, 1'b0, 1'b0, 8'd2);
        beat(1'b0, 1'b1, 4'b0100, 1'b1); expect_out("good7", 4'd7, 1'b1, 1'b0, 1'b1, 8'd2);

        // Backpressure: word 8 waits while the bin-7 result is stalled
        for (int i = 0; i < 5; i++) begin
            beat(1'b0, 1'b1, 4'b1100, 1'b0);
            chk("bp.in_ready", 32'(in_ready),  32'd0);
            chk("bp.valid",    32'(out_valid), 32'd1);
            chk("bp.bin",      32'(out_bin),   32'd7);
        end
        beat(1'b0, 1'b1, 4'b1100, 1'b1); expect_out("bp8", 4'd8, 1'b1, 1'b0, 1'b1, 8'd2);

        // Idle consume drains the output register
        beat(1'b0, 1'b0, 4'b1100, 1'b1);
        chk("drain.valid",    32'(out_valid), 32'd0);
        chk("drain.bin",      32'(out_bin),   32'd8);
        chk("drain.in_ready", 32'(in_ready),  32'd1);

        // Reset mid-stream drops the presented word
        beat(1'b0, 1'b1, 4'b1101, 1'b1); expect_out("s9", 4'd9, 1'b1, 1'b0, 1'b1, 8'd2);
        beat(1'b1, 1'b1, 4'b1101, 1'b1);
        expect_reset("mrst");
        beat(1'b0, 1'b1, 4'b0110, 1'b1); expect_out("post4", 4'd4, 1'b0, 1'b0, 1'b1, 8'd0);
        // Repeat word is a bad step
        beat(1'b0, 1'b1, 4'b0110, 1'b1); expect_out("rep4", 4'd4, 1'b0, 1'b1, 1'b1, 8'd1);
        beat(1'b0, 1'b0, 4'b0000, 1'b1);

        // Saturation with a 2-bit counter
        beat2(1'b1, 1'b0, 4'b0000);
        chk("sat.rst", 32'(err_count2), 32'd0);
        beat2(1'b0, 1'b1, 4'b0000);
        chk("sat.first.cnt",  32'(err_count2), 32'd0);
        chk("sat.first.lock", 32'(locked2),    32'd1);
        beat2(1'b0, 1'b1, 4'b0000); chk("sat.b1", 32'(err_count2), 32'd1);
        beat2(1'b0, 1'b1, 4'b0000); chk("sat.b2", 32'(err_count2), 32'd2);
        chk("sat.unlock", 32'(locked2), 32'd0);
        beat2(1'b0, 1'b1, 4'b0000); chk("sat.b3", 32'(err_count2), 32'd3);
        beat2(1'b0, 1'b1, 4'b0000); chk("sat.b4", 32'(err_count2), 32'd3);
        beat2(1'b0, 1'b1, 4'b0000); chk("sat.b5", 32'(err_count2), 32'd3);
        chk("sat.err", 32'(out_err2), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gray_step_checker.md
Name: gray_step_checker

Overview:
- Downstream consumer of the 4-bit binary-to-Gray converter stage.
- Accepts a stream of Gray-coded words over a valid/ready handshake and converts each word back to binary.
- Checks that each new word is exactly one count step (±1, modulo 2^WIDTH) from the previous word, and reports count direction.
- Maintains a lock state and a saturating error counter, then presents the result on a registered valid/ready output.

Parameters:
- WIDTH, 4, width of the Gray/binary word.
- ERR_CNT_W, 8, width of the saturating error counter.
- LOCK_N, 2, consecutive bad steps that drop lock; also consecutive good steps that regain it. Must be ≥1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_gray is valid.
- in_ready  out  1  block can accept a word.
- in_gray  in  WIDTH  Gray-coded input word.
- out_valid  out  1  output register holds a result.
- out_ready  in  1  downstream accepts the result.
- out_bin  out  WIDTH  binary equivalent of the accepted word.
- out_dir  out  1  1 = up step, 0 = down step.
- out_err  out  1  accepted word was not a ±1 step.
- locked  out  1  state == LOCKED.
- err_count  out  ERR_CNT_W  total error beats, saturating.

Behaviour:
- Reset: only the synchronous rst is used; rst is already decided as synchronous, active-high. On rst:
  - out_valid=0, out_bin=0, out_dir=0, out_err=0, locked=0, err_count=0.
  - state=EMPTY; reference register ref_bin=0; run counters=0.
  - rst overrides any in-flight handshake; a word presented in the rst cycle is dropped.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept occurs when in_valid && in_ready.
  - Latency is 1 cycle: a word accepted at edge N is on the outputs after edge N with out_valid=1.
  - Outputs are held stable while out_valid && !out_ready.
  - out_valid clears after a consumed beat only if no new accept occurs in the same cycle.
  - Full throughput is one word per cycle when out_ready=1.
- Conversion (combinational): b[WIDTH-1]=g[WIDTH-1]; b[i]=b[i+1]^g[i] for i down to 0.
- Step classification on accept, comparing b against ref_bin, modulo 2^WIDTH:
  - b == ref_bin+1: good step, dir=1.
  - b == ref_bin-1: good step, dir=0.
  - Anything else, including a repeat: bad step. err=1 and out_dir holds its previous value.
- ref_bin is updated to b on every accept (resync to the latest word).
- Wrap-around is a good step: 15→0 is up, 0→15 is down (WIDTH=4).
- err_count increments on every bad beat in any state except EMPTY, saturating at 2^ERR_CNT_W-1.
- State machine (state advances only on accept):
  - EMPTY: first accept → LOCKED; err=0, dir=0, nothing counted.
  - LOCKED: a bad step increments bad_run; a good step clears bad_run. When bad_run reaches LOCK_N → UNLOCKED and bad_run clears.
  - UNLOCKED: a good step increments good_run; a bad step clears good_run. When good_run reaches LOCK_N → LOCKED and good_run clears.
- locked changes in the same edge as the accept that causes the transition.
- Simultaneous consume and accept: the new result replaces the old one, out_valid stays 1, no bubble.

Decomposition:
- Package gray_chk_pkg:
  - State enum {EMPTY, LOCKED, UNLOCKED}.
  - Default WIDTH/ERR_CNT_W/LOCK_N constants.
  - Step-class encoding {STEP_UP, STEP_DN, STEP_BAD}.
- Sub-module gray2bin: parameterised WIDTH, purely combinational, reusable by other converter labs.
- Top-level logic: step compare, FSM, counters, output register.

Test Plan:
- After rst, feed gray 0000, 0001, 0011, 0010 with out_ready=1 → out_bin 0, 1, 2, 3 on consecutive cycles; out_dir=1 from the 2nd beat; out_err=0; locked=1; err_count=0.
- Wrap: feed 1000 (bin 15) then 0000 → out_bin 15 then 0, dir=1, err=0. Then feed 1000 → bin 15, dir=0, err=0.
- Error and lock loss: from locked at bin 0, feed 0011 (bin 2) then 0111 (bin 5):
  - Both beats give out_err=1; err_count ends at 2; locked=0 after the 2nd beat.
  - Then feed 0101 (bin 6) and 0100 (bin 7) → locked=1 after bin 7; err_count stays 2.
- Backpressure: hold out_ready=0 with out_valid=1 → in_ready=0 and out_bin stable for 5 cycles, no words lost. Raise out_ready → the next word appears the following cycle.
- Reset mid-stream: assert rst with in_valid=1 at bin 9 → next cycle all outputs 0 and state EMPTY. The first word afterwards (gray 0110, bin 4) gives err=0 and locked=1.
- Saturation: with ERR_CNT_W=2, feed 5 bad beats → err_count sticks at 3.
